dc_pio_arb: RTL and testbench

DC_PIO_ARB -- requirements
Module: dc_pio_arb

---
 rtl/usb_pkg.sv | 37 +++
 rtl/dc_pio_arb_if.sv | 48 ++++
 rtl/dc_pio_arb_rr_arb2.sv | 79 +++++++
 rtl/dc_pio_arb.sv | 150 +++++++++++++++
 tb/tb_dc_pio_arb.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : usb_pkg                                                   |
// | Purpose  : Shared types and constants for the DC PIO bus arbiter:    |
// |            FSM state encoding, requester indices, default strobe and |
// |            recovery timing, and the counter-load helper.             |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  // Requester indices into the I_REQ / I_LOCK / I_WR / I_CMD / O_ACK vectors
  localparam int REQ_CMD  = 0;
  localparam int REQ_DATA = 1;

  // Default bus timing in clocks at 50 MHz
  localparam int DEF_STROBE_CYC   = 4;
  localparam int DEF_RECOVERY_CYC = 8;

  // Phase counter wide enough for the largest legal recovery (31)
  localparam int CNT_W = 5;

  // Counters run down to zero, so a phase of N clocks loads N-1.
  function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dc_pio_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dc_pio_arb_if                                             |
// | Purpose  : Bundles the two requester handshakes and the split DC PIO |
// |            bus of dc_pio_arb.                                        |
// | Signals  : I_REQ/I_LOCK/I_WR/I_CMD [1:0] requester controls,         |
// |            I_WDATA0/I_WDATA1 write data, O_ACK [1:0] done pulses,    |
// |            O_RDATA read data, O_OWNER, O_BUSY status,                |
// |            O_DC_ADDR, O_DC_CSF/RDF/WRF strobes, O_DC_WDATA,          |
// |            O_DC_OE, I_DC_RDATA bus side.                             |
// | Modports : slave  - the arbiter                                      |
// |            master - requesters plus bus model                        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface dc_pio_arb_if;

  logic [1:0]  I_REQ;
  logic [1:0]  I_LOCK;
  logic [1:0]  I_WR;
  logic [1:0]  I_CMD;
  logic [15:0] I_WDATA0;
  logic [15:0] I_WDATA1;
  logic [1:0]  O_ACK;
  logic [15:0] O_RDATA;
  logic        O_OWNER;
  logic        O_BUSY;
  logic [1:0]  O_DC_ADDR;
  logic        O_DC_CSF;
  logic        O_DC_RDF;
  logic        O_DC_WRF;
  logic [15:0] O_DC_WDATA;
  logic        O_DC_OE;
  logic [15:0] I_DC_RDATA;

  modport slave (
    input  I_REQ, I_LOCK, I_WR, I_CMD, I_WDATA0, I_WDATA1, I_DC_RDATA,
    output O_ACK, O_RDATA, O_OWNER, O_BUSY, O_DC_ADDR,
           O_DC_CSF, O_DC_RDF, O_DC_WRF, O_DC_WDATA, O_DC_OE
  );

  modport master (
    output I_REQ, I_LOCK, I_WR, I_CMD, I_WDATA0, I_WDATA1, I_DC_RDATA,
    input  O_ACK, O_RDATA, O_OWNER, O_BUSY, O_DC_ADDR,
           O_DC_CSF, O_DC_RDF, O_DC_WRF, O_DC_WDATA, O_DC_OE
  );

endinterface
`default_nettype wire

// File: rtl/dc_pio_arb_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arb2                                                   |
// | Purpose  : Two-way round-robin arbiter with bus lock. Decides in the |
// |            cycle en_i is high; the winner is registered as owner.    |
// | Ports    : clk_i, rst_i   clock, synchronous active-high reset       |
// |            en_i           arbitration allowed (FSM idle)             |
// |            req_i[1:0]     requests                                   |
// |            lock_i[1:0]    per-requester lock request                 |
// |            ack_i          access completing; samples owner's lock    |
// |            gnt_o          grant decided this cycle                   |
// |            winner_o       index of the winner this cycle             |
// |            owner_o        registered current/last owner              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic       ack_i,
  output logic       gnt_o,
  output logic       winner_o,
  output logic       owner_o
);

  logic prio_q;   // requester favoured on a tie
  logic owner_q;
  logic lock_q;   // owner held lock when its last access completed
  logic lock_active;

  // The lock lapses in the first idle cycle the owner drops I_LOCK, and the
  // other requester may win in that same cycle.
  assign lock_active = lock_q & lock_i[owner_q];

  always_comb begin
    gnt_o    = 1'b0;
    winner_o = owner_q;
    if (en_i) begin
      if (lock_active) begin
        // Locked: only the owner can be granted; otherwise the bus idles.
        gnt_o    = req_i[owner_q];
        winner_o = owner_q;
      end else begin
        gnt_o = |req_i;
        unique case (req_i)
          2'b01:   winner_o = 1'b0;
          2'b10:   winner_o = 1'b1;
          2'b11:   winner_o = prio_q;
          default: winner_o = owner_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      if (gnt_o) begin
        owner_q <= winner_o;
        prio_q  <= ~winner_o;
      end
      if (en_i && lock_q && !lock_i[owner_q]) begin
        lock_q <= 1'b0;
      end
      if (ack_i) begin
        lock_q <= lock_i[owner_q];
      end
    end
  end

  assign owner_o = owner_q;

endmodule
`default_nettype wire

// File: rtl/dc_pio_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dc_pio_arb                                                |
// | Purpose  : Arbitrates two requesters (command engine, bulk data      |
// |            mover) onto the DC PIO bus and sequences each access      |
// |            IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE with   |
// |            glitch-free registered strobes.                           |
// | Ports    : I_CLK  50 MHz clock                                       |
// |            I_RST  synchronous active-high reset                      |
// |            bus    dc_pio_arb_if.slave: requester handshakes and the  |
// |                   split DC bus (tristate is at chip top level)       |
// | Params   : STROBE_CYC   RDF/WRF low width in clocks, 1..15           |
// |            RECOVERY_CYC RECOVER length in clocks, 1..31              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dc_pio_arb
  import usb_pkg::*;
#(
  parameter int STROBE_CYC   = DEF_STROBE_CYC,
  parameter int RECOVERY_CYC = DEF_RECOVERY_CYC
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  dc_pio_arb_if.slave   bus
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_q;
  logic [1:0]       addr_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic             csf_q;
  logic             rdf_q;
  logic             wrf_q;
  logic             oe_q;
  logic             busy_q;
  logic [1:0]       ack_q;

  logic             arb_en;
  logic             arb_gnt;
  logic             arb_winner;
  logic             owner;

  assign arb_en = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk_i    (I_CLK),
    .rst_i    (I_RST),
    .en_i     (arb_en),
    .req_i    (bus.I_REQ),
    .lock_i   (bus.I_LOCK),
    .ack_i    (|ack_q),
    .gnt_o    (arb_gnt),
    .winner_o (arb_winner),
    .owner_o  (owner)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= 2'b10;
      wdata_q <= '0;
      rdata_q <= '0;
      csf_q   <= 1'b1;
      rdf_q   <= 1'b1;
      wrf_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 2'b00;
    end else begin
      ack_q <= 2'b00;
      unique case (state_q)
        ST_IDLE: begin
          if (arb_gnt) begin
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
            csf_q   <= 1'b0;
            wr_q    <= bus.I_WR[arb_winner];
            oe_q    <= bus.I_WR[arb_winner];
            addr_q  <= {1'b1, bus.I_CMD[arb_winner]};
            wdata_q <= (arb_winner == 1'(REQ_DATA)) ? bus.I_WDATA1 : bus.I_WDATA0;
          end
        end
        ST_SETUP: begin
          state_q <= ST_STROBE;
          cnt_q   <= cyc_load(STROBE_CYC);
          if (wr_q) begin
            wrf_q <= 1'b0;
          end else begin
            rdf_q <= 1'b0;
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            state_q <= ST_HOLD;
            rdf_q   <= 1'b1;
            wrf_q   <= 1'b1;
            // Last strobe clock: device data has settled
            if (!wr_q) begin
              rdata_q <= bus.I_DC_RDATA;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          state_q      <= ST_RECOVER;
          cnt_q        <= cyc_load(RECOVERY_CYC);
          oe_q         <= 1'b0;
          ack_q[owner] <= 1'b1;
        end
        ST_RECOVER: begin
          // CSF stays low through the ACK clock, so chip select spans
          // STROBE_CYC+3 clocks and the high gap equals RECOVERY_CYC.
          csf_q <= 1'b1;
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          csf_q   <= 1'b1;
          rdf_q   <= 1'b1;
          wrf_q   <= 1'b1;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.O_ACK      = ack_q;
  assign bus.O_RDATA    = rdata_q;
  assign bus.O_OWNER    = owner;
  assign bus.O_BUSY     = busy_q;
  assign bus.O_DC_ADDR  = addr_q;
  assign bus.O_DC_CSF   = csf_q;
  assign bus.O_DC_RDF   = rdf_q;
  assign bus.O_DC_WRF   = wrf_q;
  assign bus.O_DC_WDATA = wdata_q;
  assign bus.O_DC_OE    = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_dc_pio_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dc_pio_arb                                             |
// | Purpose  : Directed self-checking bench for dc_pio_arb: default      |
// |            timing instance plus a STROBE_CYC=1/RECOVERY_CYC=1 one.   |
// | Ports    : none                                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_dc_pio_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dc_pio_arb_if bus();
  dc_pio_arb_if bus_f();

  dc_pio_arb dut (
    .I_CLK (clk),
    .I_RST (rst),
    .bus   (bus)
  );

  dc_pio_arb #(.STROBE_CYC(1), .RECOVERY_CYC(1)) dut_f (
    .I_CLK (clk),
    .I_RST (rst),
    .bus   (bus_f)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Per-cycle observation of the default instance, sampled on negedge
  int n_csf = 0, n_rdf = 0, n_wrf = 0, n_oe = 0, n_both = 0, n_both_f = 0;
  int hi_run = 0;
  bit seen_low = 1'b0;
  int gaps[$];
  int acks[$];
  int fack_cyc[$];

  always @(negedge clk) begin
    if (!bus.O_DC_CSF) n_csf++;
    if (!bus.O_DC_RDF) n_rdf++;
    if (!bus.O_DC_WRF) n_wrf++;
    if (bus.O_DC_OE)   n_oe++;
    if (!bus.O_DC_RDF && !bus.O_DC_WRF)     n_both++;
    if (!bus_f.O_DC_RDF && !bus_f.O_DC_WRF) n_both_f++;
    if (bus.O_DC_CSF) begin
      hi_run++;
    end else begin
      if (seen_low && hi_run > 0) gaps.push_back(hi_run);
      hi_run   = 0;
      seen_low = 1'b1;
    end
    if (bus.O_ACK[0]) acks.push_back(0);
    if (bus.O_ACK[1]) acks.push_back(1);
    if (bus_f.O_ACK[0]) fack_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stimulus and sampling point: 1 ns after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_csf = 0; n_rdf = 0; n_wrf = 0; n_oe = 0;
    hi_run = 0; seen_low = 1'b0;
    gaps.delete();
    acks.delete();
  endtask

  task automatic set_req(input int who, input bit req, input bit lock, input bit wr,
                         input bit cmd, input logic [15:0] wd);
    bus.I_REQ[who]  = req;
    bus.I_LOCK[who] = lock;
    bus.I_WR[who]   = wr;
    bus.I_CMD[who]  = cmd;
    if (who == 0) bus.I_WDATA0 = wd;
    else          bus.I_WDATA1 = wd;
  endtask

  // lat counts the request clock as clock 1
  task automatic wait_ack(input int who, input string tag, output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (bus.O_ACK[who]) begin
        lat = n + 1;
        break;
      end
    end
    if (lat < 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    bit found;

    bus.I_REQ = '0;   bus.I_LOCK = '0;  bus.I_WR = '0;  bus.I_CMD = '0;
    bus.I_WDATA0 = '0; bus.I_WDATA1 = '0; bus.I_DC_RDATA = '0;
    bus_f.I_REQ = '0; bus_f.I_LOCK = '0; bus_f.I_WR = '0; bus_f.I_CMD = '0;
    bus_f.I_WDATA0 = '0; bus_f.I_WDATA1 = '0; bus_f.I_DC_RDATA = '0;
    rst = 1'b1;
    repeat (3) tick();

    // Reset values
    chk("rst_csf",   bus.O_DC_CSF, 1);
    chk("rst_rdf",   bus.O_DC_RDF, 1);
    chk("rst_wrf",   bus.O_DC_WRF, 1);
    chk("rst_oe",    bus.O_DC_OE, 0);
    chk("rst_ack",   bus.O_ACK, 0);
    chk("rst_busy",  bus.O_BUSY, 0);
    chk("rst_owner", bus.O_OWNER, 0);
    chk("rst_rdata", bus.O_RDATA, 0);
    chk("rst_wdata", bus.O_DC_WDATA, 0);
    chk("rst_addr",  bus.O_DC_ADDR, 2'b10);
    rst = 1'b0;
    tick();

    // Single command-port write from requester 0
    clear_mon();
    set_req(0, 1, 0, 1, 1, 16'h00B5);
    wait_ack(0, "wr0_ack", lat);
    chk("wr0_lat",   lat, 8);
    chk("wr0_addr",  bus.O_DC_ADDR, 2'b11);
    chk("wr0_wdata", bus.O_DC_WDATA, 16'h00B5);
    chk("wr0_owner", bus.O_OWNER, 0);
    set_req(0, 0, 0, 0, 0, 16'h0000);
    repeat (10) tick();
    chk("wr0_csf_low", n_csf, 7);
    chk("wr0_wrf_low", n_wrf, 4);
    chk("wr0_rdf_low", n_rdf, 0);
    chk("wr0_oe_high", n_oe, 6);
    chk("wr0_nacks",   acks.size(), 1);
    chk("wr0_idle",    bus.O_BUSY, 0);

    // Single data-port read from requester 1
    clear_mon();
    bus.I_DC_RDATA = 16'h3630;
    set_req(1, 1, 0, 0, 0, 16'h0000);
    wait_ack(1, "rd1_ack", lat);
    chk("rd1_lat",   lat, 8);
    chk("rd1_rdata", bus.O_RDATA, 16'h3630);
    chk("rd1_addr",  bus.O_DC_ADDR, 2'b10);
    chk("rd1_owner", bus.O_OWNER, 1);
    set_req(1, 0, 0, 0, 0, 16'h0000);
    bus.I_DC_RDATA = 16'h0000;
    repeat (10) tick();
    chk("rd1_rdf_low", n_rdf, 4);
    chk("rd1_wrf_low", n_wrf, 0);
    chk("rd1_oe_high", n_oe, 0);
    chk("rd1_rdata_hold", bus.O_RDATA, 16'h3630);

    // Simultaneous requests from reset: strict alternation 0,1,0,1
    do_reset();
    clear_mon();
    set_req(0, 1, 0, 1, 1, 16'h0011);
    set_req(1, 1, 0, 0, 0, 16'h0000);
    for (int n = 0; n < 200 && acks.size() < 4; n++) tick();
    set_req(0, 0, 0, 0, 0, 16'h0000);
    set_req(1, 0, 0, 0, 0, 16'h0000);
    repeat (12) tick();
    chk("rr_nacks", acks.size(), 4);
    while (acks.size() < 4) acks.push_back(9);
    chk("rr_ack0", acks[0], 0);
    chk("rr_ack1", acks[1], 1);
    chk("rr_ack2", acks[2], 0);
    chk("rr_ack3", acks[3], 1);
    chk("rr_ngaps", gaps.size(), 3);
    while (gaps.size() < 3) gaps.push_back(0);
    chk("rr_gap0", gaps[0], 8);
    chk("rr_gap1", gaps[1], 8);
    chk("rr_gap2", gaps[2], 8);

    // Requester 0 locks for a command write plus two reads
    do_reset();
    clear_mon();
    bus.I_DC_RDATA = 16'hA5C3;
    set_req(1, 1, 0, 0, 0, 16'h0000);
    set_req(0, 1, 1, 1, 1, 16'h00FE);
    wait_ack(0, "lk_cmd", lat);
    chk("lk_cmd_wdata", bus.O_DC_WDATA, 16'h00FE);
    // Owner drops its request but keeps the lock: bus must stay idle
    set_req(0, 0, 1, 0, 0, 16'h0000);
    repeat (14) tick();
    chk("lk_idle_busy",  bus.O_BUSY, 0);
    chk("lk_idle_nacks", acks.size(), 1);
    set_req(0, 1, 1, 0, 0, 16'h0000);
    wait_ack(0, "lk_rd1", lat);
    chk("lk_rd1_lat", lat, 8);
    wait_ack(0, "lk_rd2", lat);
    chk("lk_rd2_rdata", bus.O_RDATA, 16'hA5C3);
    set_req(0, 0, 0, 0, 0, 16'h0000);
    wait_ack(1, "lk_gnt1", lat);
    set_req(1, 0, 0, 0, 0, 16'h0000);
    repeat (12) tick();
    chk("lk_nacks", acks.size(), 4);
    while (acks.size() < 4) acks.push_back(9);
    chk("lk_seq0", acks[0], 0);
    chk("lk_seq1", acks[1], 0);
    chk("lk_seq2", acks[2], 0);
    chk("lk_seq3", acks[3], 1);

    // Reset during the strobe of a write
    clear_mon();
    set_req(0, 1, 0, 1, 0, 16'h0F0F);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (!bus.O_DC_WRF) begin
        found = 1'b1;
        break;
      end
    end
    chk("rs_strobe_seen", found, 1);
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0, 16'h0000);
    tick();
    chk("rs_csf",  bus.O_DC_CSF, 1);
    chk("rs_rdf",  bus.O_DC_RDF, 1);
    chk("rs_wrf",  bus.O_DC_WRF, 1);
    chk("rs_oe",   bus.O_DC_OE, 0);
    chk("rs_ack",  bus.O_ACK, 0);
    chk("rs_busy", bus.O_BUSY, 0);
    rst = 1'b0;
    repeat (12) tick();
    chk("rs_no_ack", acks.size(), 0);
    set_req(0, 1, 0, 1, 0, 16'h0F0F);
    wait_ack(0, "rs_fresh", lat);
    chk("rs_fresh_lat", lat, 8);
    set_req(0, 0, 0, 0, 0, 16'h0000);
    repeat (10) tick();
    chk("rs_fresh_nacks", acks.size(), 1);

    // Minimum timing, locked back-to-back writes
    fack_cyc.delete();
    n_both_f = 0;
    bus_f.I_LOCK[0]  = 1'b1;
    bus_f.I_WR[0]    = 1'b1;
    bus_f.I_CMD[0]   = 1'b1;
    bus_f.I_WDATA0   = 16'h5A5A;
    bus_f.I_REQ[0]   = 1'b1;
    for (int n = 0; n < 100 && fack_cyc.size() < 5; n++) tick();
    bus_f.I_REQ[0]  = 1'b0;
    bus_f.I_LOCK[0] = 1'b0;
    repeat (6) tick();
    chk("fast_nacks", fack_cyc.size(), 5);
    while (fack_cyc.size() < 5) fack_cyc.push_back(0);
    chk("fast_gap1", fack_cyc[1] - fack_cyc[0], 5);
    chk("fast_gap2", fack_cyc[2] - fack_cyc[1], 5);
    chk("fast_gap3", fack_cyc[3] - fack_cyc[2], 5);
    chk("fast_gap4", fack_cyc[4] - fack_cyc[3], 5);
    chk("fast_rdwr_both", n_both_f, 0);
    chk("dflt_rdwr_both", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
